// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit CPU: opcode map, field widths, beat count and IR reset value.
package cpu_pkg;
    localparam int OPW       = 3;
    localparam int AW        = 5;
    localparam int CNTW      = 8;
    localparam int NUM_BEATS = 8;

    localparam logic [OPW-1:0] OP_LD  = 3'b000;
    localparam logic [OPW-1:0] OP_ADD = 3'b001;
    localparam logic [OPW-1:0] OP_SUB = 3'b010;
    localparam logic [OPW-1:0] OP_AND = 3'b011;
    localparam logic [OPW-1:0] OP_OR  = 3'b100;
    localparam logic [OPW-1:0] OP_STO = 3'b101;
    localparam logic [OPW-1:0] OP_NOP = 3'b110;
    localparam logic [OPW-1:0] OP_HLT = 3'b111;

    localparam logic [7:0] IR_RST = 8'hC0;
endpackage

// File: rtl/beat_ring.sv
// One-hot machine-beat ring T0..T7 with NOP short-cycle and HLT stall at T3.
//   beat | meaning
//   T0-T2| fetch; IR captured on the T2->T3 edge
//   T3   | decode valid; NOP returns to T0, HLT holds here
//   T4-T7| execute; T7->T0 retires the instruction
module beat_ring
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adv,
    input  logic                 short,
    input  logic                 stall,
    output logic [NUM_BEATS-1:0] t
);
    localparam logic [NUM_BEATS-1:0] BEAT_T0 = NUM_BEATS'(1);

    logic [NUM_BEATS-1:0] t_next;

    always_comb begin
        t_next = t;
        if (adv) begin
            if (t[3] && stall)
                t_next = t;
            else if (t[3] && short)
                t_next = BEAT_T0;
            else
                t_next = {t[NUM_BEATS-2:0], t[NUM_BEATS-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            t <= BEAT_T0;
        else
            t <= t_next;
    end
endmodule

// File: rtl/timing_decode.sv
// Beat generator and instruction decoder: IR capture, one-hot opcode decode,
// sticky halt and retired-instruction counter around the beat ring.
module timing_decode
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [7:0]      bus_in,
    input  logic            iir_n,
    output logic            T0,
    output logic            T1,
    output logic            T2,
    output logic            T3,
    output logic            T4,
    output logic            T5,
    output logic            T6,
    output logic            T7,
    output logic            LD,
    output logic            ADD,
    output logic            SUB,
    output logic            AND,
    output logic            OR,
    output logic            STO,
    output logic            HLT,
    output logic            halted,
    output logic [AW-1:0]   ir_addr,
    output logic [CNTW-1:0] icount
);
    logic [7:0]           ir;
    logic [OPW-1:0]       opcode;
    logic [NUM_BEATS-1:0] t;
    logic                 adv;
    logic                 is_nop;
    logic                 is_hlt;
    logic                 retire;

    assign opcode  = ir[7:5];
    assign ir_addr = ir[AW-1:0];
    assign is_nop  = (opcode == OP_NOP);
    assign is_hlt  = (opcode == OP_HLT);
    assign adv     = run & ~halted;
    assign retire  = adv & (t[7] | (t[3] & is_nop));

    beat_ring u_ring (
        .clk   (clk),
        .rst   (rst),
        .adv   (adv),
        .short (is_nop),
        .stall (is_hlt),
        .t     (t)
    );

    assign {T7, T6, T5, T4, T3, T2, T1, T0} = t;

    // IR load is deliberately ungated by run/halted; the control block owns the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ir <= IR_RST;
        else if (!iir_n)
            ir <= bus_in;
    end

    always_comb begin
        LD  = 1'b0;
        ADD = 1'b0;
        SUB = 1'b0;
        AND = 1'b0;
        OR  = 1'b0;
        STO = 1'b0;
        HLT = 1'b0;
        case (opcode)
            OP_LD:   LD  = 1'b1;
            OP_ADD:  ADD = 1'b1;
            OP_SUB:  SUB = 1'b1;
            OP_AND:  AND = 1'b1;
            OP_OR:   OR  = 1'b1;
            OP_STO:  STO = 1'b1;
            OP_HLT:  HLT = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            halted <= 1'b0;
        else if (adv && t[3] && is_hlt)
            halted <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            icount <= '0;
        else if (retire)
            icount <= icount + CNTW'(1);
    end
endmodule

// File: tb/tb_timing_decode.sv
// Directed-vector bench for timing_decode: fetch/execute beats, NOP, HLT, run stall,
// async reset mid-instruction and icount wrap.
module tb_timing_decode;
    logic       clk;
    logic       rst;
    logic       run;
    logic [7:0] bus_in;
    logic       iir_n;
    logic T0, T1, T2, T3, T4, T5, T6, T7;
    logic LD, ADD, SUB, AND, OR, STO, HLT;
    logic       halted;
    logic [4:0] ir_addr;
    logic [7:0] icount;

    int total = 0;
    int bad   = 0;

    timing_decode dut (
        .clk(clk), .rst(rst), .run(run), .bus_in(bus_in), .iir_n(iir_n),
        .T0(T0), .T1(T1), .T2(T2), .T3(T3), .T4(T4), .T5(T5), .T6(T6), .T7(T7),
        .LD(LD), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .STO(STO), .HLT(HLT),
        .halted(halted), .ir_addr(ir_addr), .icount(icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] beats();
        return {T7, T6, T5, T4, T3, T2, T1, T0};
    endfunction

    // {LD, ADD, SUB, AND, OR, STO, HLT}
    function automatic logic [6:0] dec();
        return {LD, ADD, SUB, AND, OR, STO, HLT};
    endfunction

    // Advance one edge, then emulate the control block driving iir_n = ~T2.
    task automatic tick();
        @(posedge clk);
        #1;
        iir_n = ~T2;
    endtask

    task automatic release_reset();
        #2;
        rst   = 1'b0;
        iir_n = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; bus_in = 8'h00; iir_n = 1'b1;
        #12;
        if (beats() !== 8'b0000_0001) begin bad++; $display("FAIL reset_beats got=%b want=%b", beats(), 8'b1); end
        total++;
        if (dec() !== 7'b0) begin bad++; $display("FAIL reset_dec got=%b want=%b", dec(), 7'b0); end
        total++;
        if (ir_addr !== 5'd0 || halted !== 1'b0 || icount !== 8'd0) begin
            bad++; $display("FAIL reset_state addr=%0d halted=%b icount=%0d want 0/0/0", ir_addr, halted, icount);
        end
        total++;
        @(posedge clk); #1;
        release_reset();
    endtask

    task automatic test_add();
        bus_in = 8'h25; run = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (beats() !== (8'b1 << k)) begin bad++; $display("FAIL add_beat k=%0d got=%b want=%b", k, beats(), 8'b1 << k); end
            total++;
            if (k >= 3) begin
                if (dec() !== 7'b0100000 || ir_addr !== 5'd5) begin
                    bad++; $display("FAIL add_dec k=%0d got=%b/%0d want=%b/5", k, dec(), ir_addr, 7'b0100000);
                end
                total++;
            end
            tick();
        end
        if (beats() !== 8'b1 || icount !== 8'd1) begin bad++; $display("FAIL add_wrap beats=%b icount=%0d want 00000001/1", beats(), icount); end
        total++;
    endtask

    task automatic test_nop();
        bus_in = 8'hC3;
        for (int k = 0; k < 4; k++) begin
            if (beats() !== (8'b1 << k)) begin bad++; $display("FAIL nop_beat k=%0d got=%b want=%b", k, beats(), 8'b1 << k); end
            total++;
            tick();
        end
        if (beats() !== 8'b1 || icount !== 8'd2) begin bad++; $display("FAIL nop_wrap beats=%b icount=%0d want 00000001/2", beats(), icount); end
        total++;
    endtask

    task automatic test_sub_run_stall();
        logic [7:0] seq [0:12];
        logic [7:0] exp_cnt [0:12];
        logic       run_at [0:12];
        // Beat and icount at each sample; run value applied before the following edge.
        seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h20, 8'h20, 8'h20, 8'h40, 8'h80, 8'h80, 8'h01};
        exp_cnt = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3};
        run_at = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        bus_in = 8'h41;
        for (int k = 0; k < 13; k++) begin
            if (beats() !== seq[k] || icount !== exp_cnt[k]) begin
                bad++; $display("FAIL sub_step k=%0d beats=%b icount=%0d want %b/%0d", k, beats(), icount, seq[k], exp_cnt[k]);
            end
            total++;
            if (k == 4) begin
                if (dec() !== 7'b0010000 || ir_addr !== 5'd1) begin bad++; $display("FAIL sub_dec got=%b/%0d want=%b/1", dec(), ir_addr, 7'b0010000); end
                total++;
            end
            run = run_at[k];
            if (k < 12) tick();
        end
        run = 1'b1;
    endtask

    task automatic test_async_reset();
        bus_in = 8'hA7;
        for (int k = 0; k < 6; k++) tick();
        if (beats() !== 8'h40 || STO !== 1'b1 || icount !== 8'd3) begin
            bad++; $display("FAIL sto_t6 beats=%b STO=%b icount=%0d want 01000000/1/3", beats(), STO, icount);
        end
        total++;
        #2;
        rst = 1'b1;
        #1;
        if (beats() !== 8'b1 || STO !== 1'b0 || icount !== 8'd0) begin
            bad++; $display("FAIL async_rst beats=%b STO=%b icount=%0d want 00000001/0/0", beats(), STO, icount);
        end
        total++;
        @(posedge clk); #1;
        release_reset();
        bus_in = 8'h1F;
        tick();
        if (beats() !== 8'b10) begin bad++; $display("FAIL post_rst_t1 got=%b want=%b", beats(), 8'b10); end
        total++;
        tick(); tick();
        if (beats() !== 8'h08 || dec() !== 7'b1000000 || ir_addr !== 5'd31) begin
            bad++; $display("FAIL ld_fetch beats=%b dec=%b addr=%0d want 00001000/%b/31", beats(), dec(), ir_addr, 7'b1000000);
        end
        total++;
        for (int k = 0; k < 5; k++) tick();
        if (beats() !== 8'b1 || icount !== 8'd1) begin bad++; $display("FAIL ld_retire beats=%b icount=%0d want 00000001/1", beats(), icount); end
        total++;
    endtask

    task automatic test_halt();
        bus_in = 8'hE0;
        tick(); tick(); tick();
        if (beats() !== 8'h08 || HLT !== 1'b1 || halted !== 1'b0) begin
            bad++; $display("FAIL hlt_t3 beats=%b HLT=%b halted=%b want 00001000/1/0", beats(), HLT, halted);
        end
        total++;
        tick();
        if (beats() !== 8'h08 || halted !== 1'b1) begin bad++; $display("FAIL hlt_set beats=%b halted=%b want 00001000/1", beats(), halted); end
        total++;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (beats() !== 8'h08 || halted !== 1'b1 || icount !== 8'd1) begin
                bad++; $display("FAIL hlt_frozen k=%0d beats=%b halted=%b icount=%0d want 00001000/1/1", k, beats(), halted, icount);
            end
            total++;
        end
        bus_in = 8'h1F; iir_n = 1'b0;
        @(posedge clk); #1;
        iir_n = 1'b1;
        if (LD !== 1'b1 || ir_addr !== 5'd31 || beats() !== 8'h08 || halted !== 1'b1) begin
            bad++; $display("FAIL hlt_ir_load LD=%b addr=%0d beats=%b halted=%b want 1/31/00001000/1", LD, ir_addr, beats(), halted);
        end
        total++;
        tick(); tick();
        if (beats() !== 8'h08 || icount !== 8'd1) begin bad++; $display("FAIL hlt_sticky beats=%b icount=%0d want 00001000/1", beats(), icount); end
        total++;
        #2;
        rst = 1'b1;
        #1;
        if (beats() !== 8'b1 || halted !== 1'b0) begin bad++; $display("FAIL hlt_rst beats=%b halted=%b want 00000001/0", beats(), halted); end
        total++;
        @(posedge clk); #1;
        release_reset();
    endtask

    task automatic test_icount_wrap();
        bus_in = 8'hC3;
        for (int n = 0; n < 255; n++) begin
            tick(); tick(); tick(); tick();
        end
        if (icount !== 8'd255 || beats() !== 8'b1) begin bad++; $display("FAIL wrap_255 icount=%0d beats=%b want 255/00000001", icount, beats()); end
        total++;
        tick(); tick(); tick();
        if (dec() !== 7'b0 || ir_addr !== 5'd3) begin bad++; $display("FAIL wrap_nop_dec dec=%b addr=%0d want 0/3", dec(), ir_addr); end
        total++;
        tick();
        if (icount !== 8'd0 || beats() !== 8'b1) begin bad++; $display("FAIL wrap_0 icount=%0d beats=%b want 0/00000001", icount, beats()); end
        total++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_nop();
        test_sub_run_stall();
        test_async_reset();
        test_halt();
        test_icount_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
